// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall sequencer: load-use and branch-operand bubbles, dmem freeze, taken-branch flush, memory watchdog.
// Optional performance counters are enabled with the HAZ_PERF_CNT_EN macro.
module hazard_stall_ctrl #(
   parameter int unsigned TMO_W       = 8,
   parameter int unsigned MEM_TIMEOUT = 200
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [4:0]  id_rs1_i,
   input  logic [4:0]  id_rs2_i,
   input  logic        id_uses_rs2_i,
   input  logic        id_is_branch_i,
   input  logic        branch_taken_i,
   input  logic        ex_mem_read_i,
   input  logic        ex_reg_write_i,
   input  logic [4:0]  ex_rd_i,
   input  logic        dmem_stall_i,
   output logic        pc_write_o,
   output logic        if_id_write_o,
   output logic        if_id_flush_o,
   output logic        id_ex_bubble_o,
   output logic        id_ex_hold_o,
   output logic        ex_mem_hold_o,
   output logic [1:0]  state_o,
   output logic        err_o,
   output logic [31:0] stall_cnt_o,
   output logic [31:0] flush_cnt_o
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LU2      = 2'd1,
      MEM_WAIT = 2'd2
   } state_e;

   localparam logic [TMO_W-1:0] WD_LAST = TMO_W'(MEM_TIMEOUT - 1);
   localparam logic [TMO_W-1:0] WD_MAX  = '1;

   state_e            state_q, state_d;
   state_e            saved_q, saved_d;
   state_e            eff_state;
   logic [TMO_W-1:0]  wd_q, wd_d;
   logic              err_q, err_d;
   logic              rs_match, lu_hit, br_hit;

   assign rs_match = (ex_rd_i == id_rs1_i) || (id_uses_rs2_i && (ex_rd_i == id_rs2_i));
   assign lu_hit   = ex_mem_read_i && (ex_rd_i != 5'd0) && rs_match;
   assign br_hit   = id_is_branch_i && ex_reg_write_i && !ex_mem_read_i && (ex_rd_i != 5'd0) && rs_match;

   // After a memory stall releases, behave as the state that was interrupted.
   assign eff_state = (state_q == MEM_WAIT) ? saved_q : state_q;

   always_comb begin
      pc_write_o     = 1'b1;
      if_id_write_o  = 1'b1;
      if_id_flush_o  = 1'b0;
      id_ex_bubble_o = 1'b0;
      id_ex_hold_o   = 1'b0;
      ex_mem_hold_o  = 1'b0;
      state_d        = RUN;
      saved_d        = saved_q;
      if (!rst_i) begin
         pc_write_o     = 1'b0;
         if_id_write_o  = 1'b0;
         if_id_flush_o  = 1'b1;
         id_ex_bubble_o = 1'b1;
         saved_d        = RUN;
      end else if (dmem_stall_i) begin
         pc_write_o    = 1'b0;
         if_id_write_o = 1'b0;
         id_ex_hold_o  = 1'b1;
         ex_mem_hold_o = 1'b1;
         state_d       = MEM_WAIT;
         saved_d       = eff_state;
      end else if (eff_state == LU2) begin
         pc_write_o     = 1'b0;
         if_id_write_o  = 1'b0;
         id_ex_bubble_o = 1'b1;
      end else if (lu_hit || br_hit) begin
         pc_write_o     = 1'b0;
         if_id_write_o  = 1'b0;
         id_ex_bubble_o = 1'b1;
         state_d        = (lu_hit && id_is_branch_i) ? LU2 : RUN;
      end else if (branch_taken_i) begin
         if_id_flush_o = 1'b1;
      end
   end

   // Watchdog counts consecutive stalled cycles and saturates.
   always_comb begin
      wd_d  = '0;
      err_d = err_q;
      if (dmem_stall_i) begin
         wd_d = (wd_q == WD_MAX) ? wd_q : wd_q + TMO_W'(1);
         if (wd_q == WD_LAST) err_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q <= RUN;
         saved_q <= RUN;
         wd_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         saved_q <= saved_d;
         wd_q    <= wd_d;
         err_q   <= err_d;
      end
   end

   assign state_o = state_q;
   assign err_o   = err_q;

`ifdef HAZ_PERF_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q + (pc_write_o ? 32'd0 : 32'd1);
      flush_cnt_d = flush_cnt_q + (if_id_flush_o ? 32'd1 : 32'd0);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;
`else
   assign stall_cnt_o = 32'd0;
   assign flush_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed-vector bench for hazard_stall_ctrl, built with MEM_TIMEOUT = 4.
module tb_hazard_stall_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [4:0]  id_rs1_i, id_rs2_i, ex_rd_i;
   logic        id_uses_rs2_i, id_is_branch_i, branch_taken_i;
   logic        ex_mem_read_i, ex_reg_write_i, dmem_stall_i;
   logic        pc_write_o, if_id_write_o, if_id_flush_o;
   logic        id_ex_bubble_o, id_ex_hold_o, ex_mem_hold_o;
   logic [1:0]  state_o;
   logic        err_o;
   logic [31:0] stall_cnt_o, flush_cnt_o;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   // {pc_write, if_id_write, flush, bubble, id_ex_hold, ex_mem_hold}
   localparam logic [5:0] O_DEF  = 6'b110000;
   localparam logic [5:0] O_BUB  = 6'b000100;
   localparam logic [5:0] O_FLU  = 6'b111000;
   localparam logic [5:0] O_HOLD = 6'b000011;
   localparam logic [5:0] O_RST  = 6'b001100;

   hazard_stall_ctrl #(.TMO_W(8), .MEM_TIMEOUT(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_uses_rs2_i(id_uses_rs2_i),
      .id_is_branch_i(id_is_branch_i), .branch_taken_i(branch_taken_i),
      .ex_mem_read_i(ex_mem_read_i), .ex_reg_write_i(ex_reg_write_i), .ex_rd_i(ex_rd_i),
      .dmem_stall_i(dmem_stall_i),
      .pc_write_o(pc_write_o), .if_id_write_o(if_id_write_o), .if_id_flush_o(if_id_flush_o),
      .id_ex_bubble_o(id_ex_bubble_o), .id_ex_hold_o(id_ex_hold_o), .ex_mem_hold_o(ex_mem_hold_o),
      .state_o(state_o), .err_o(err_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the edge; outputs are sampled 1 unit later.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [5:0] exp_o, input logic [1:0] exp_st, input logic exp_err);
      #1;
      check_val({tag, ".outs"},
                32'({pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o, id_ex_hold_o, ex_mem_hold_o}),
                32'(exp_o));
      check_val({tag, ".state"}, 32'(state_o), 32'(exp_st));
      check_val({tag, ".err"}, 32'(err_o), 32'(exp_err));
   endtask

   task automatic clear_inputs();
      id_rs1_i = 5'd0; id_rs2_i = 5'd0; ex_rd_i = 5'd0;
      id_uses_rs2_i = 1'b0; id_is_branch_i = 1'b0; branch_taken_i = 1'b0;
      ex_mem_read_i = 1'b0; ex_reg_write_i = 1'b0; dmem_stall_i = 1'b0;
   endtask

   logic [31:0] flush_base;

   initial begin
      clear_inputs();
      rst_i = 1'b0;
      tick(); tick();
      chk("reset", O_RST, 2'd0, 1'b0);
      check_val("reset.stall_cnt", stall_cnt_o, 32'd0);
      check_val("reset.flush_cnt", flush_cnt_o, 32'd0);
      rst_i = 1'b1;
      chk("idle", O_DEF, 2'd0, 1'b0);

      // load-use, non-branch: single bubble
      ex_mem_read_i = 1'b1; ex_rd_i = 5'd5; id_rs1_i = 5'd5;
      chk("lu", O_BUB, 2'd0, 1'b0);
      tick(); ex_mem_read_i = 1'b0;
      chk("lu.after", O_DEF, 2'd0, 1'b0);

      // load-to-branch: two bubbles, taken ignored
      ex_mem_read_i = 1'b1; id_is_branch_i = 1'b1; branch_taken_i = 1'b1;
      chk("lub.c1", O_BUB, 2'd0, 1'b0);
      tick(); ex_mem_read_i = 1'b0;
      chk("lub.c2", O_BUB, 2'd1, 1'b0);
      tick();
      chk("lub.resolve", O_FLU, 2'd0, 1'b0);
      clear_inputs();

      // ALU-to-branch on rs2
      ex_reg_write_i = 1'b1; ex_rd_i = 5'd7; id_rs2_i = 5'd7; id_uses_rs2_i = 1'b1; id_is_branch_i = 1'b1;
      chk("br", O_BUB, 2'd0, 1'b0);
      tick(); ex_reg_write_i = 1'b0;
      chk("br.after", O_DEF, 2'd0, 1'b0);
      ex_reg_write_i = 1'b1; ex_rd_i = 5'd0; id_rs2_i = 5'd0; id_rs1_i = 5'd0;
      chk("br.rd0", O_DEF, 2'd0, 1'b0);
      ex_reg_write_i = 1'b0; ex_mem_read_i = 1'b1;
      chk("lu.rd0", O_DEF, 2'd0, 1'b0);
      clear_inputs();

      // taken branch, no hazard
      id_is_branch_i = 1'b1; branch_taken_i = 1'b1;
      #1 flush_base = flush_cnt_o;
      chk("taken", O_FLU, 2'd0, 1'b0);
      tick(); clear_inputs();
      chk("taken.after", O_DEF, 2'd0, 1'b0);
`ifdef HAZ_PERF_CNT_EN
      check_val("flush_cnt.inc", flush_cnt_o, flush_base + 32'd1);
`else
      check_val("flush_cnt.tied", flush_cnt_o, 32'd0);
      check_val("stall_cnt.tied", stall_cnt_o, 32'd0);
`endif

      // memory stall for 3 cycles while in LU2
      ex_mem_read_i = 1'b1; ex_rd_i = 5'd3; id_rs1_i = 5'd3; id_is_branch_i = 1'b1;
      tick(); ex_mem_read_i = 1'b0; dmem_stall_i = 1'b1;
      chk("lu2.stall1", O_HOLD, 2'd1, 1'b0);
      tick();
      chk("lu2.stall2", O_HOLD, 2'd2, 1'b0);
      tick();
      chk("lu2.stall3", O_HOLD, 2'd2, 1'b0);
      tick(); dmem_stall_i = 1'b0;
      chk("lu2.release", O_BUB, 2'd2, 1'b0);
      tick();
      chk("lu2.run", O_DEF, 2'd0, 1'b0);
      clear_inputs();

      // watchdog: 6 stall cycles, err after the 4th
      dmem_stall_i = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         chk($sformatf("wd.c%0d", i), O_HOLD, (i == 1) ? 2'd0 : 2'd2, (i > 4) ? 1'b1 : 1'b0);
         tick();
      end
      dmem_stall_i = 1'b0;
      chk("wd.release", O_DEF, 2'd2, 1'b1);
      tick();
      chk("wd.sticky", O_DEF, 2'd0, 1'b1);

      // reset in the middle of a stall
      dmem_stall_i = 1'b1;
      tick();
      rst_i = 1'b0;
      chk("rst.mid", O_RST, 2'd2, 1'b1);
      tick();
      chk("rst.after", O_RST, 2'd0, 1'b0);
      rst_i = 1'b1; dmem_stall_i = 1'b0;
      chk("rst.release", O_DEF, 2'd0, 1'b0);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
